frame_transmit: RTL and testbench
=================================

# frame_transmit

Serial frame transmitter that produces the line stream consumed by the frame receiver: start bit, 4-bit frame size, 1–15 data bytes, CRC-8, stop bit, all MSB first. Sits directly upstream of the receiver. Accepts a parallel frame plus a bit-period setting, serialises it onto `TX` one bit per `baudrate+1` clocks, and reports busy/done. Pure transmit path: no bit stuffing and no noise handling.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request to send; sampled only while `busy`=0.
- `framesize`  input  4  number of data bytes (1–15); latched on accepted `start`.
- `framedata`  input  128  frame payload; byte k = `framedata[(15-k)*8+7 : (15-k)*8]`, so byte 0 = `[127:120]`; latched on accepted `start`.
- `baudrate`  input  8  bit period minus one, in clocks; latched on accepted `start`.
- `TX`  output  1  serial line; idle level 0.
- `busy`  output  1  high from the cycle after an accepted `start` through the last stop-bit cycle.
- `done`  output  1  one-cycle pulse after the stop bit completes.
- `reject`  output  1  one-cycle pulse when `start` is seen with `framesize`=0 while idle.

## Operation
- States: IDLE, START, SIZE, DATA, CRC, STOP.
- IDLE: `TX`=0, `busy`=0.
  - `start`=1 and `framesize`≠0: latch inputs, clear CRC to 0x00, go to START.
  - `start`=1 and `framesize`=0: pulse `reject`, stay in IDLE.
- START: `TX`=1 for one bit period.
- SIZE: send `framesize[3]`…`[0]`.
- DATA: send bytes 0…`framesize-1`, each `[7]`…`[0]`; 3-bit bit counter, 4-bit byte counter.
- CRC: send the CRC register `[7]`…`[0]`, frozen at entry.
- STOP: `TX`=0 for one bit period. Then go to IDLE, pulse `done`, drop `busy`.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, serial MSB-first. Matches the codebase `crc` block.
  - Updated once per bit, with each SIZE and DATA bit only: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0x00).
  - Start, CRC and stop bits are excluded.
- Bit timing: an 8-bit baud counter counts 0…`baudrate`; the bit advances when counter==`baudrate`. `baudrate`=0 gives 1 clock/bit; 255 gives 256 clocks/bit.
- Frame length: 14 + 8·`framesize` bits.
- Bytes beyond `framesize` are never sent; `framedata[7:0]` (byte 15) is unreachable.

## Timing
- Reset values: `TX`=0, `busy`=0, `done`=0, `reject`=0, state IDLE, all counters 0, CRC 0x00.
- Reset has priority over everything, including mid-frame. The next cycle shows the reset values, and no `done` pulse is generated.
- `start` accepted in cycle T:
  - Start bit on `TX` in cycles T+1…T+(B) (B = `baudrate`+1).
  - `busy`=1 in T+1…T+L·B (L = frame length).
  - Cycle T+L·B+1: `done`=1, `busy`=0, `TX`=0.
- `start` while `busy`=1 is ignored, with no effect. Input changes after the accept cycle have no effect on the frame in flight.
- `start` in the `done` cycle is accepted, giving a 1-cycle minimum idle gap between frames.
- `reject` pulses in the cycle after the sampled `start`. `busy` stays 0 and `TX` stays 0.
- `TX` is registered and glitch-free; it changes only at bit boundaries.

## Test plan
- Basic frame: `baudrate`=0, `framesize`=1, `framedata[127:120]`=0xA5, `start` pulse at T.
  - `TX` over T+1…T+22 = 1, 0001, 10100101, 01100111 (CRC 0x67), 0.
  - `done` at T+23; `busy` high T+1…T+22.
- Bit period: same frame with `baudrate`=3. Each bit is held exactly 4 cycles; `done` at T+89.
- Zero size: `framesize`=0 with `start`. `reject` at T+1; `busy`, `TX` and `done` stay 0.
- Max frame and busy-ignore:
  - `framesize`=15, `baudrate`=0. 134 bits; `done` at T+135.
  - Last data byte = `framedata[15:8]`.
  - `start` and new `framedata` applied mid-frame change nothing.
- Reset mid-frame: assert `reset` during DATA.
  - Next cycle `TX`=0, `busy`=0, no `done`.
  - A new `start` afterwards produces a correct frame with fresh CRC.
- Back-to-back: `start` held high continuously. Frames repeat with exactly one idle cycle (`TX`=0, `done`=1) between them.

Source files
------------

// File: rtl/frame_transmit.sv
// frame_transmit: serialises a start bit, 4-bit frame size, 1-15 data bytes,
// CRC-8 (poly 0x07, init 0x00) and a stop bit onto TX, MSB first, with a
// programmable bit period of baudrate+1 clocks.
module frame_transmit (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   framesize,
    input  logic [127:0] framedata,
    input  logic [7:0]   baudrate,
    output logic         TX,
    output logic         busy,
    output logic         done,
    output logic         reject
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SIZE,
        DATA,
        CRC,
        STOP
    } state_t;

    state_t         state;
    logic [3:0]     size_q;
    logic [127:0]   data_q;
    logic [7:0]     baud_q;
    logic [7:0]     baud_cnt;
    logic [2:0]     bit_cnt;
    logic [3:0]     byte_cnt;
    logic [7:0]     crc;
    logic           bit_end;

    // One serial MSB-first CRC-8 step for polynomial x^8+x^2+x+1.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Bit b of byte k, where byte 0 lives in [127:120]: index (15-k)*8+b.
    function automatic logic data_bit(input logic [127:0] d, input logic [3:0] k,
                                      input logic [2:0] b);
        return d[{~k, b}];
    endfunction

    // Last clock of the current bit period.
    assign bit_end = (baud_cnt == baud_q);

    // Frame sequencer: every TX value is loaded at a bit boundary so the line
    // is a plain flop output; the CRC absorbs each SIZE/DATA bit as it is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            TX       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            reject   <= 1'b0;
            baud_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 4'd0;
            crc      <= 8'h00;
            size_q   <= 4'd0;
            baud_q   <= 8'd0;
            // NOTE: the 128-bit payload holding register is left out of reset;
            // it is always reloaded on an accepted start before it is read.
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register sees the pre-edge values of the others.
            done   <= 1'b0;
            reject <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= bit_end ? 8'd0 : baud_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    TX   <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (framesize == 4'd0) begin
                            reject <= 1'b1;
                        end else begin
                            size_q   <= framesize;
                            data_q   <= framedata;
                            baud_q   <= baudrate;
                            crc      <= 8'h00;
                            baud_cnt <= 8'd0;
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 4'd0;
                            TX       <= 1'b1;
                            busy     <= 1'b1;
                            state    <= START;
                        end
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= SIZE;
                        bit_cnt <= 3'd3;
                        TX      <= size_q[3];
                        crc     <= crc_step(crc, size_q[3]);
                    end
                end

                SIZE: begin
                    if (bit_end) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            TX      <= size_q[bit_cnt[1:0] - 2'd1];
                            crc     <= crc_step(crc, size_q[bit_cnt[1:0] - 2'd1]);
                        end else begin
                            state    <= DATA;
                            byte_cnt <= 4'd0;
                            bit_cnt  <= 3'd7;
                            TX       <= data_bit(data_q, 4'd0, 3'd7);
                            crc      <= crc_step(crc, data_bit(data_q, 4'd0, 3'd7));
                        end
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            TX      <= data_bit(data_q, byte_cnt, bit_cnt - 3'd1);
                            crc     <= crc_step(crc, data_bit(data_q, byte_cnt, bit_cnt - 3'd1));
                        end else if (byte_cnt == size_q - 4'd1) begin
                            state   <= CRC;
                            bit_cnt <= 3'd7;
                            TX      <= crc[7];
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                            bit_cnt  <= 3'd7;
                            TX       <= data_bit(data_q, byte_cnt + 4'd1, 3'd7);
                            crc      <= crc_step(crc, data_bit(data_q, byte_cnt + 4'd1, 3'd7));
                        end
                    end
                end

                CRC: begin
                    if (bit_end) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            TX      <= crc[bit_cnt - 3'd1];
                        end else begin
                            state <= STOP;
                            TX    <= 1'b0;
                        end
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        TX    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    TX    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_transmit.sv
// Directed testbench for frame_transmit: checks the serial stream cycle by
// cycle against a frame built from the line format, plus reject, reset and
// back-to-back behaviour.
module tb_frame_transmit;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   framesize;
    logic [127:0] framedata;
    logic [7:0]   baudrate;
    logic         TX;
    logic         busy;
    logic         done;
    logic         reject;

    int tests = 0;
    int fails = 0;

    frame_transmit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .framesize (framesize),
        .framedata (framedata),
        .baudrate  (baudrate),
        .TX        (TX),
        .busy      (busy),
        .done      (done),
        .reject    (reject)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Expected line bits, index 0 = first bit on the wire.
    task automatic build(input logic [3:0] size, input logic [127:0] data,
                         output logic [133:0] bits, output int len);
        logic [7:0] c;
        logic       b;
        int         n;
        bits = '0;
        c    = 8'h00;
        n    = 0;
        bits[n] = 1'b1;
        n++;
        for (int i = 3; i >= 0; i--) begin
            b = size[i];
            bits[n] = b;
            n++;
            c = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
        end
        for (int k = 0; k < int'(size); k++) begin
            for (int i = 7; i >= 0; i--) begin
                b = data[(15 - k) * 8 + i];
                bits[n] = b;
                n++;
                c = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
            end
        end
        for (int i = 7; i >= 0; i--) begin
            bits[n] = c[i];
            n++;
        end
        bits[n] = 1'b0;
        n++;
        len = n;
    endtask

    // Send one frame and check every cycle up to one past the done pulse.
    // With abuse set, start and new inputs are driven mid-frame.
    task automatic run_frame(input string name, input logic [3:0] size,
                             input logic [127:0] data, input logic [7:0] baud,
                             input bit abuse, output logic [133:0] obs);
        logic [133:0] exp_bits;
        int len;
        int b;
        int bitn;
        build(size, data, exp_bits, len);
        b   = int'(baud) + 1;
        obs = '0;
        @(negedge clk);
        framesize = size;
        framedata = data;
        baudrate  = baud;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (reject !== 1'b0) begin
            fails++;
            $display("FAIL %s reject: got %b, expected 0", name, reject);
        end
        for (int k = 1; k <= len * b; k++) begin
            if (k > 1) @(negedge clk);
            if (abuse && k == 10) begin
                start     = 1'b1;
                framedata = ~data;
                framesize = 4'd3;
                baudrate  = 8'd7;
            end
            if (abuse && k == len * b) start = 1'b0;
            bitn = (k - 1) / b;
            if ((k - 1) % b == 0) obs[bitn] = TX;
            tests++;
            if (TX !== exp_bits[bitn] || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s cycle T+%0d: TX=%b busy=%b done=%b, expected TX=%b busy=1 done=0",
                         name, k, TX, busy, done, exp_bits[bitn]);
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || TX !== 1'b0) begin
            fails++;
            $display("FAIL %s done cycle T+%0d: done=%b busy=%b TX=%b, expected 1 0 0",
                     name, len * b + 1, done, busy, TX);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s after done: done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        framesize = 4'd0;
        framedata = '0;
        baudrate  = 8'd0;
        repeat (3) @(negedge clk);
        tests++;
        if ({TX, busy, done, reject} !== 4'b0000) begin
            fails++;
            $display("FAIL reset values: TX/busy/done/reject=%b, expected 0000",
                     {TX, busy, done, reject});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [133:0] obs;
        logic [21:0]  got;
        logic [7:0]   crc_got;
        run_frame("basic", 4'd1, {8'hA5, 120'h0}, 8'd0, 1'b0, obs);
        for (int i = 0; i < 22; i++) got[21 - i] = obs[i];
        tests++;
        if (got !== 22'b1_0001_10100101_01100111_0) begin
            fails++;
            $display("FAIL basic stream: got %b, expected %b", got, 22'b1_0001_10100101_01100111_0);
        end
        for (int i = 0; i < 8; i++) crc_got[7 - i] = obs[13 + i];
        tests++;
        if (crc_got !== 8'h67) begin
            fails++;
            $display("FAIL basic crc: got %h, expected 67", crc_got);
        end
    endtask

    task automatic test_bit_period();
        logic [133:0] obs;
        logic [21:0]  got;
        run_frame("bit_period", 4'd1, {8'hA5, 120'h0}, 8'd3, 1'b0, obs);
        for (int i = 0; i < 22; i++) got[21 - i] = obs[i];
        tests++;
        if (got !== 22'b1_0001_10100101_01100111_0) begin
            fails++;
            $display("FAIL bit_period stream: got %b, expected %b", got, 22'b1_0001_10100101_01100111_0);
        end
    endtask

    task automatic test_zero_size();
        @(negedge clk);
        framesize = 4'd0;
        framedata = {8'hFF, 120'h0};
        baudrate  = 8'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (reject !== 1'b1 || busy !== 1'b0 || TX !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL zero_size T+1: reject=%b busy=%b TX=%b done=%b, expected 1 0 0 0",
                     reject, busy, TX, done);
        end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            tests++;
            if (reject !== 1'b0 || busy !== 1'b0 || TX !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL zero_size T+%0d: reject=%b busy=%b TX=%b done=%b, expected 0 0 0 0",
                         k, reject, busy, TX, done);
            end
        end
    endtask

    task automatic test_max_frame();
        logic [133:0] obs;
        logic [7:0]   last;
        run_frame("max_frame", 4'd15, 128'h00112233445566778899AABBCCDDEEFF, 8'd0, 1'b1, obs);
        for (int i = 0; i < 8; i++) last[7 - i] = obs[117 + i];
        tests++;
        if (last !== 8'hEE) begin
            fails++;
            $display("FAIL max_frame last byte: got %h, expected ee", last);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [133:0] obs;
        @(negedge clk);
        framesize = 4'd2;
        framedata = {16'h3CC3, 112'h0};
        baudrate  = 8'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (TX !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_frame: TX=%b busy=%b done=%b, expected 0 0 0", TX, busy, done);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            tests++;
            if (TX !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_frame idle %0d: TX=%b busy=%b done=%b, expected 0 0 0",
                         k, TX, busy, done);
            end
        end
        run_frame("after_reset", 4'd2, {16'h5A0F, 112'h0}, 8'd1, 1'b0, obs);
    endtask

    task automatic test_back_to_back();
        logic [133:0] exp_bits;
        int len;
        int pos;
        build(4'd1, {8'hA5, 120'h0}, exp_bits, len);
        @(negedge clk);
        framesize = 4'd1;
        framedata = {8'hA5, 120'h0};
        baudrate  = 8'd0;
        start     = 1'b1;
        for (int k = 1; k <= 2 * (len + 1); k++) begin
            @(negedge clk);
            if (k == 2 * (len + 1)) start = 1'b0;
            pos = (k - 1) % (len + 1);
            tests++;
            if (pos == len) begin
                if (done !== 1'b1 || busy !== 1'b0 || TX !== 1'b0) begin
                    fails++;
                    $display("FAIL back_to_back gap T+%0d: done=%b busy=%b TX=%b, expected 1 0 0",
                             k, done, busy, TX);
                end
            end else if (TX !== exp_bits[pos] || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL back_to_back T+%0d: TX=%b busy=%b done=%b, expected TX=%b busy=1 done=0",
                         k, TX, busy, done, exp_bits[pos]);
            end
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || TX !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back stop: busy=%b TX=%b, expected 0 0", busy, TX);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_period();
        test_zero_size();
        test_max_frame();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
